regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter_if.sv | 35 +++
 rtl/regfile_write_arbiter.sv | 113 +++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter_if.sv
// Writeback, issue and scoreboard signals between the pipeline and the write arbiter.
// The arbiter takes the slave modport; the pipeline (or bench) drives through master.
interface regfile_write_arbiter_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_is_load;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic        stall;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [31:0] pending;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data,
    output iss_valid, iss_rd, iss_is_load, rs1_addr, rs2_addr,
    input  ld_ready, stall, rf_we, rf_waddr, rf_wdata, pending
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data,
    input  iss_valid, iss_rd, iss_is_load, rs1_addr, rs2_addr,
    output ld_ready, stall, rf_we, rf_waddr, rf_wdata, pending
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// Single register-file write port shared by ALU writeback (priority) and a load-return FIFO,
// plus a load scoreboard that produces the issue-stage hazard stall.
module regfile_write_arbiter #(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  regfile_write_arbiter_if.slave bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [4:0]    fifo_rd   [DEPTH];
  logic [31:0]   fifo_data [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic          full;
  logic          empty;
  logic          alu_sel;
  logic          push;
  logic          pop;
  logic          from_fifo;
  logic          stall_int;
  logic [31:0]   pend_q;
  logic [31:0]   pend_set;
  logic [31:0]   pend_clr;

  assign full  = (count == CNT_FULL);
  assign empty = (count == '0);

  // Ready comes only from registered occupancy, and is held low while reset is asserted.
  assign bus.ld_ready = reset_n & ~full;

  assign alu_sel = bus.alu_valid && (bus.alu_rd != 5'd0);
  assign push    = bus.ld_valid && bus.ld_ready && (bus.ld_rd != 5'd0);
  assign pop     = !alu_sel && !empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd[wr_ptr]   <= bus.ld_rd;
      fifo_data[wr_ptr] <= bus.ld_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.rf_we    <= 1'b0;
      bus.rf_waddr <= 5'd0;
      bus.rf_wdata <= 32'd0;
      from_fifo    <= 1'b0;
    end else if (alu_sel) begin
      bus.rf_we    <= 1'b1;
      bus.rf_waddr <= bus.alu_rd;
      bus.rf_wdata <= bus.alu_data;
      from_fifo    <= 1'b0;
    end else if (pop) begin
      bus.rf_we    <= 1'b1;
      bus.rf_waddr <= fifo_rd[rd_ptr];
      bus.rf_wdata <= fifo_data[rd_ptr];
      from_fifo    <= 1'b1;
    end else begin
      bus.rf_we    <= 1'b0;
      from_fifo    <= 1'b0;
    end
  end

  // Hazard check sees only the registered scoreboard; a clear landing this cycle is not forwarded.
  always_comb begin
    stall_int = ((bus.rs1_addr != 5'd0) && pend_q[bus.rs1_addr]) ||
                ((bus.rs2_addr != 5'd0) && pend_q[bus.rs2_addr]) ||
                (bus.iss_valid && (bus.iss_rd != 5'd0) && pend_q[bus.iss_rd]);
  end

  assign bus.stall = stall_int;

  always_comb begin
    pend_set = 32'd0;
    pend_clr = 32'd0;
    if (bus.iss_valid && bus.iss_is_load && (bus.iss_rd != 5'd0) && !stall_int)
      pend_set = 32'd1 << bus.iss_rd;
    if (bus.rf_we && from_fifo)
      pend_clr = 32'd1 << bus.rf_waddr;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pend_q <= 32'd0;
    else          pend_q <= ((pend_q & ~pend_clr) | pend_set) & ~32'd1;
  end

  assign bus.pending = pend_q;

endmodule
